// File: rtl/mine_placer_safe_if.sv
// rtl/mine_placer_safe_if.sv - request/response handshake bundle for mine_placer_safe
interface mine_placer_safe_if #(
    parameter int BOARD_W = 8,
    parameter int BOARD_H = 8
) ();
    localparam int CNT_W = $clog2(BOARD_W * BOARD_H + 1);
    localparam int XW    = $clog2(BOARD_W);
    localparam int YW    = $clog2(BOARD_H);

    logic             start;
    logic             ack;
    logic [CNT_W-1:0] total_mines_in;
    logic [XW-1:0]    safe_x;
    logic [YW-1:0]    safe_y;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, ack, total_mines_in, safe_x, safe_y,
        input  busy, done, err
    );

    modport slave (
        input  start, ack, total_mines_in, safe_x, safe_y,
        output busy, done, err
    );
endinterface

// File: rtl/mine_placer_safe.sv
// rtl/mine_placer_safe.sv - places N distinct pseudo-random mines outside a first-click safe zone
module mine_placer_safe #(
    parameter int                BOARD_W = 8,
    parameter int                BOARD_H = 8,
    parameter int                SAFE_R  = 1,
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter int                CNT_W   = $clog2(BOARD_W * BOARD_H + 1),
    localparam int               XW      = $clog2(BOARD_W),
    localparam int               YW      = $clog2(BOARD_H)
) (
    input  logic                  clk_tb,
    input  logic                  reset_tb,
    mine_placer_safe_if.slave     req,
    input  logic                  mine_read_value,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic                  place_mine_en,
    output logic [2:0]            q_state
);
    // Fixed capacity: the full safe square is always subtracted, even when clipped by an edge.
    localparam int CAP_RAW = BOARD_W * BOARD_H - (2 * SAFE_R + 1) * (2 * SAFE_R + 1);
    localparam int CAP     = (CAP_RAW < 0) ? 0 : CAP_RAW;

    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form).
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_DRAW  = 3'd1,
        S_CHECK = 3'd2,
        S_PLACE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [XW-1:0]      r_safe_x;
    logic [YW-1:0]      r_safe_y;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_place_en;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [LFSR_W-1:0]  w_lfsr_next;
    logic signed [XW:0] w_dx;
    logic signed [YW:0] w_dy;
    logic               w_in_safe;
    logic               w_reject;

    // Candidate rejection: off-board, inside the safe square, or already mined.
    always_comb begin
        w_lfsr_next = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
        w_dx        = $signed({1'b0, r_x}) - $signed({1'b0, r_safe_x});
        w_dy        = $signed({1'b0, r_y}) - $signed({1'b0, r_safe_y});
        w_in_safe   = (int'(w_dx) <= SAFE_R) && (int'(w_dx) >= -SAFE_R) &&
                      (int'(w_dy) <= SAFE_R) && (int'(w_dy) >= -SAFE_R);
        w_reject    = (int'(r_x) >= BOARD_W) || (int'(r_y) >= BOARD_H) ||
                      w_in_safe || mine_read_value;
    end

    // Placement FSM with registered Moore outputs; LFSR free-runs in every state.
    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            r_state     <= S_INIT;
            r_lfsr      <= SEED;
            r_x         <= '0;
            r_y         <= '0;
            r_safe_x    <= '0;
            r_safe_y    <= '0;
            r_remaining <= '0;
            r_place_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_INIT: begin
                    if (req.start) begin
                        r_safe_x <= req.safe_x;
                        r_safe_y <= req.safe_y;
                        if (int'(req.total_mines_in) > CAP) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (req.total_mines_in == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_state     <= S_DRAW;
                            r_busy      <= 1'b1;
                            r_remaining <= req.total_mines_in;
                        end
                    end
                end
                S_DRAW: begin
                    r_x     <= r_lfsr[XW-1:0];
                    r_y     <= r_lfsr[XW+YW-1:XW];
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_reject) begin
                        r_state <= S_DRAW;
                    end else begin
                        r_state    <= S_PLACE;
                        r_place_en <= 1'b1;
                    end
                end
                S_PLACE: begin
                    r_place_en  <= 1'b0;
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_DRAW;
                    end
                end
                S_DONE: begin
                    if (req.ack) begin
                        r_state <= S_INIT;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_INIT;
                    r_place_en <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end

    assign x             = r_x;
    assign y             = r_y;
    assign place_mine_en = r_place_en;
    assign q_state       = r_state;
    assign req.busy      = r_busy;
    assign req.done      = r_done;
    assign req.err       = r_err;
endmodule

// File: tb/tb_mine_placer_safe.sv
// tb/tb_mine_placer_safe.sv - scoreboard bench for mine_placer_safe
module tb_mine_placer_safe;
    logic clk_tb   = 1'b0;
    logic reset_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit err;
        int pulses;
        bit full;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // 8x8 board, R=1
    mine_placer_safe_if #(.BOARD_W(8), .BOARD_H(8)) if_a ();
    logic        mrv_a, pme_a;
    logic [2:0]  xa, ya, qs_a;
    logic [63:0] board_a;
    logic        clr_a = 1'b0;
    int          sx_a = 3, sy_a = 3, cnt_a = 0;

    mine_placer_safe #(.BOARD_W(8), .BOARD_H(8), .SAFE_R(1)) dut_a (
        .clk_tb(clk_tb), .reset_tb(reset_tb), .req(if_a), .mine_read_value(mrv_a),
        .x(xa), .y(ya), .place_mine_en(pme_a), .q_state(qs_a)
    );

    assign mrv_a = board_a[{ya, xa}];
    always @(posedge clk_tb) begin
        if (clr_a) board_a <= '0;
        else if (pme_a) board_a[{ya, xa}] <= 1'b1;
    end

    // 5x7 board, R=0
    mine_placer_safe_if #(.BOARD_W(5), .BOARD_H(7)) if_b ();
    logic        mrv_b, pme_b;
    logic [2:0]  xb, yb, qs_b;
    logic [63:0] board_b;
    logic        clr_b = 1'b0;
    int          cnt_b = 0;

    mine_placer_safe #(.BOARD_W(5), .BOARD_H(7), .SAFE_R(0)) dut_b (
        .clk_tb(clk_tb), .reset_tb(reset_tb), .req(if_b), .mine_read_value(mrv_b),
        .x(xb), .y(yb), .place_mine_en(pme_b), .q_state(qs_b)
    );

    assign mrv_b = board_b[{yb, xb}];
    always @(posedge clk_tb) begin
        if (clr_b) board_b <= '0;
        else if (pme_b) board_b[{yb, xb}] <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outside_mask(int sx, int sy, int r);
        logic [63:0] m;
        m = '0;
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++)
                if (!((xx - sx <= r) && (sx - xx <= r) && (yy - sy <= r) && (sy - yy <= r)))
                    m[yy*8+xx] = 1'b1;
        return m;
    endfunction

    // Monitor A: per-pulse legality, then pop and compare on each done rising edge.
    initial begin
        bit   prev;
        bit   in_safe;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_tb);
            if (!reset_tb) begin
                cnt_a = 0;
            end else begin
                if (pme_a) begin
                    in_safe = (int'(xa) - sx_a <= 1) && (sx_a - int'(xa) <= 1) &&
                              (int'(ya) - sy_a <= 1) && (sy_a - int'(ya) <= 1);
                    check("a_pulse_safe_or_dup", {in_safe, board_a[{ya, xa}]}, 2'b00);
                    cnt_a++;
                end
                if (if_a.done && !prev) begin
                    if (q_a.size() == 0) begin
                        check("a_unexpected_done", 1, 0);
                    end else begin
                        e = q_a.pop_front();
                        check("a_err", if_a.err, e.err);
                        check("a_pulse_count", cnt_a, e.pulses);
                        check("a_done_state", qs_a, 4);
                        if (e.full) check("a_full_board", board_a, outside_mask(sx_a, sy_a, 1));
                    end
                    cnt_a = 0;
                end
            end
            prev = if_a.done;
        end
    end

    // Monitor B: bounds, excluded click cell, duplicates, then count on done.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_tb);
            if (!reset_tb) begin
                cnt_b = 0;
            end else begin
                if (pme_b) begin
                    check("b_pulse_cell", {xb >= 3'd5, yb >= 3'd7, (xb == 3'd4 && yb == 3'd6),
                                           board_b[{yb, xb}]}, 4'b0000);
                    cnt_b++;
                end
                if (if_b.done && !prev) begin
                    if (q_b.size() == 0) begin
                        check("b_unexpected_done", 1, 0);
                    end else begin
                        e = q_b.pop_front();
                        check("b_err", if_b.err, e.err);
                        check("b_pulse_count", cnt_b, e.pulses);
                    end
                    cnt_b = 0;
                end
            end
            prev = if_b.done;
        end
    end

    task automatic run_a(input int total, input int sx, input int sy, input bit e_err,
                         input int e_pulses, input bit full, input bit disturb, input bit hold);
        int cyc;
        clr_a = 1'b1;
        @(negedge clk_tb);
        clr_a = 1'b0;
        sx_a = sx;
        sy_a = sy;
        q_a.push_back('{e_err, e_pulses, full});
        if_a.total_mines_in = 7'(total);
        if_a.safe_x = 3'(sx);
        if_a.safe_y = 3'(sy);
        if_a.start = 1'b1;
        @(negedge clk_tb);
        if_a.start = 1'b0;
        cyc = 1;
        while (!if_a.done && cyc < 20000) begin
            if (disturb) begin
                if_a.start = (qs_a == 3'd1 || qs_a == 3'd3);
                if_a.total_mines_in = 7'd50;
            end
            @(negedge clk_tb);
            cyc++;
        end
        if_a.start = 1'b0;
        check("a_done_reached", if_a.done, 1);
        if (e_pulses == 0) check("a_done_latency", cyc, 1);
        if (hold) begin
            if_a.start = 1'b1;
            repeat (3) @(negedge clk_tb);
            check("a_hold_in_done", {if_a.done, qs_a}, {1'b1, 3'd4});
        end
        if_a.ack = 1'b1;
        @(negedge clk_tb);
        if_a.ack = 1'b0;
        if_a.start = 1'b0;
        check("a_ack_to_init", {if_a.done, if_a.err, if_a.busy, qs_a}, {3'b000, 3'd0});
        @(negedge clk_tb);
        check("a_stays_init", qs_a, 0);
    endtask

    initial begin
        int cyc;
        if_a.start = 1'b0; if_a.ack = 1'b0; if_a.total_mines_in = '0;
        if_a.safe_x = '0;  if_a.safe_y = '0;
        if_b.start = 1'b0; if_b.ack = 1'b0; if_b.total_mines_in = '0;
        if_b.safe_x = '0;  if_b.safe_y = '0;
        clr_a = 1'b1;
        clr_b = 1'b1;
        repeat (2) @(negedge clk_tb);
        check("reset_state", {qs_a, xa, ya, pme_a, if_a.busy, if_a.done, if_a.err}, '0);
        reset_tb = 1'b1;
        clr_a = 1'b0;
        clr_b = 1'b0;
        @(negedge clk_tb);

        run_a(10, 3, 3, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        run_a(0,  3, 3, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        run_a(56, 3, 3, 1'b1, 0,  1'b0, 1'b0, 1'b0);
        run_a(55, 3, 3, 1'b0, 55, 1'b1, 1'b0, 1'b0);
        run_a(5,  3, 3, 1'b0, 5,  1'b0, 1'b1, 1'b1);
        run_a(20, 0, 0, 1'b0, 20, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset after the third placement of a 10-mine request.
        clr_a = 1'b1;
        @(negedge clk_tb);
        clr_a = 1'b0;
        sx_a = 3;
        sy_a = 3;
        if_a.total_mines_in = 7'd10;
        if_a.safe_x = 3'd3;
        if_a.safe_y = 3'd3;
        if_a.start = 1'b1;
        @(negedge clk_tb);
        if_a.start = 1'b0;
        cyc = 0;
        while (cnt_a < 3 && cyc < 5000) begin
            @(negedge clk_tb);
            cyc++;
        end
        check("rst_third_pulse_seen", cnt_a >= 3, 1);
        check("rst_busy_before", if_a.busy, 1);
        #7;
        reset_tb = 1'b0;
        #1;
        check("rst_immediate", {if_a.busy, pme_a, if_a.done, qs_a}, {3'b000, 3'd0});
        repeat (2) @(negedge clk_tb);
        reset_tb = 1'b1;
        @(negedge clk_tb);
        run_a(10, 3, 3, 1'b0, 10, 1'b0, 1'b0, 1'b0);

        // 5x7 board, radius 0, click in the far corner.
        clr_b = 1'b1;
        @(negedge clk_tb);
        clr_b = 1'b0;
        q_b.push_back('{1'b0, 20, 1'b0});
        if_b.total_mines_in = 6'd20;
        if_b.safe_x = 3'd4;
        if_b.safe_y = 3'd6;
        if_b.start = 1'b1;
        @(negedge clk_tb);
        if_b.start = 1'b0;
        cyc = 1;
        while (!if_b.done && cyc < 20000) begin
            @(negedge clk_tb);
            cyc++;
        end
        check("b_done_reached", if_b.done, 1);
        if_b.ack = 1'b1;
        @(negedge clk_tb);
        if_b.ack = 1'b0;
        check("b_ack_to_init", {if_b.done, qs_b}, {1'b0, 3'd0});

        repeat (3) @(negedge clk_tb);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
